// File: rtl/reg_funsel_driver.sv
// rtl/reg_funsel_driver.sv - command FIFO plus setup/pulse/hold sequencer driving a funsel/e register bank
module reg_funsel_driver #(
    parameter int NBits     = 16,
    parameter int NRegs     = 4,
    parameter int FifoDepth = 4,
    parameter int SelW      = (NRegs > 1) ? $clog2(NRegs) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_funsel,
    input  logic [SelW-1:0]  cmd_sel,
    input  logic [NBits-1:0] cmd_data,
    input  logic [3:0]       cmd_count,
    output logic [1:0]       funsel,
    output logic [NBits-1:0] i,
    output logic [NRegs-1:0] e,
    output logic             busy,
    output logic             done
);

    localparam int PtrW = $clog2(FifoDepth);
    localparam int EntW = 2 + SelW + NBits + 4;

    typedef enum logic [1:0] {IDLE, SETUP, PULSE, HOLD} state_t;

    logic [EntW-1:0]  mem [FifoDepth];
    logic [PtrW:0]    wr_ptr;
    logic [PtrW:0]    rd_ptr;
    logic             empty;
    logic             full;
    logic             push;
    logic             pop;
    logic [EntW-1:0]  head;
    logic [1:0]       head_funsel;
    logic [SelW-1:0]  head_sel;
    logic [NBits-1:0] head_data;
    logic [3:0]       head_count;

    state_t           state;
    state_t           state_next;
    logic [SelW-1:0]  cur_sel;
    logic [3:0]       rem;
    logic             fire;
    logic             dec_rem;
    logic             finish;
    logic [NRegs-1:0] onehot;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign empty     = (wr_ptr == rd_ptr);
    assign full      = (wr_ptr[PtrW] != rd_ptr[PtrW]) &&
                       (wr_ptr[PtrW-1:0] == rd_ptr[PtrW-1:0]);
    assign cmd_ready = ~full;
    assign push      = cmd_valid & ~full;
    assign busy      = ~empty | (state != IDLE);

    assign head        = mem[rd_ptr[PtrW-1:0]];
    assign head_funsel = head[EntW-1 -: 2];
    assign head_sel    = head[NBits+4 +: SelW];
    assign head_data   = head[4 +: NBits];
    assign head_count  = head[3:0];

    // Shifting past the top leaves zero, so an out-of-range index never enables anything.
    assign onehot = NRegs'(1) << cur_sel;

    // FIFO storage; contents are don't-care until written, so no reset needed.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[PtrW-1:0]] <= {cmd_funsel, cmd_sel, cmd_data, cmd_count};
        end
    end

    // FIFO pointers advance on push and on FSM pop.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + (PtrW+1)'(1);
            if (pop)  rd_ptr <= rd_ptr + (PtrW+1)'(1);
        end
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:  if (!empty) state_next = SETUP;
            SETUP: state_next = PULSE;
            PULSE: state_next = HOLD;
            HOLD: begin
                if (rem != 4'd0)  state_next = PULSE;
                else if (!empty)  state_next = SETUP;
                else              state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Per-state actions: pop a command, fire an enable pulse, count down repeats, flag completion.
    always_comb begin
        pop     = 1'b0;
        fire    = 1'b0;
        dec_rem = 1'b0;
        finish  = 1'b0;
        case (state)
            IDLE:  pop  = ~empty;
            SETUP: fire = 1'b1;
            PULSE: fire = 1'b0;
            HOLD: begin
                if (rem != 4'd0) begin
                    fire    = 1'b1;
                    dec_rem = 1'b1;
                end else begin
                    finish = 1'b1;
                    pop    = ~empty;
                end
            end
            default: pop = 1'b0;
        endcase
    end

    // Registered bank outputs; funsel/i move only when a command is popped.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            funsel  <= 2'b00;
            i       <= '0;
            e       <= '0;
            done    <= 1'b0;
            cur_sel <= '0;
            rem     <= 4'd0;
        end else begin
            e    <= fire ? onehot : '0;
            done <= finish;
            if (pop) begin
                funsel  <= head_funsel;
                i       <= head_data;
                cur_sel <= head_sel;
                rem     <= head_count;
            end else if (dec_rem) begin
                rem <= rem - 4'd1;
            end
        end
    end

endmodule
